// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared constants for the UART program loader
package loader_pkg;

  // Frame start marker
  localparam logic [7:0] HEADER = 8'hA5;

  // Frame field widths
  localparam int BYTE_W = 8;
  localparam int LEN_W  = 16;
  localparam int WORD_W = 32;

  // Frame FSM states
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_LO = 3'd1;
  localparam logic [2:0] ST_LEN_HI = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_CSUM   = 3'd4;
  localparam logic [2:0] ST_ERR    = 3'd5;

  // Byte receiver states
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_BITS  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART byte receiver with synchronizer and framing check
module uart_rx_byte
  import loader_pkg::*;
#(
  parameter int BIT_CYC = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam int CNT_W = $clog2(BIT_CYC);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(BIT_CYC / 2 - 1);

  logic [1:0]       sync;
  logic             rx_s;
  logic             rx_prev;
  logic [1:0]       rx_state;
  logic [CNT_W-1:0] timer;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  assign rx_s = sync[1];

  // Two-flop synchronizer preset to idle-high, plus a delayed copy for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync    <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync    <= {sync[0], uart_rx};
      rx_prev <= rx_s;
    end
  end

  // Bit timer: falling edge starts it, mid-start recheck rejects glitches, stop bit checked at its middle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      timer    <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s) begin
            timer    <= HALF;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else if (!rx_s) begin
            timer    <= FULL;
            bit_idx  <= '0;
            rx_state <= RX_BITS;
          end else begin
            rx_state <= RX_IDLE;
          end
        end
        RX_BITS: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else begin
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            timer   <= FULL;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else begin
            if (rx_s) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              rx_ferr <= 1'b1;
            end
            rx_state <= RX_IDLE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_rom_loader.sv
// rtl/uart_rom_loader.sv - framed UART program loader driving the instruction ROM write port
module uart_rom_loader
  import loader_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int ADDR_W      = 12,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_waddr,
  output logic [31:0]       rom_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam int BIT_CYC = CLK_FREQ / BAUD;
  localparam int TMO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [LEN_W:0]   LEN_MAX  = (LEN_W + 1)'(2 ** ADDR_W);

  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ferr;

  logic [2:0]       state;
  logic [7:0]       len_lo;
  logic [ADDR_W:0]  len_words;
  logic [ADDR_W:0]  word_cnt;
  logic [1:0]       byte_cnt;
  logic [23:0]      word_lo;
  logic [7:0]       csum;
  logic [TMO_W-1:0] tmo_cnt;

  logic [LEN_W-1:0] len_n;
  logic             len_bad;
  logic             active;

  uart_rx_byte #(.BIT_CYC(BIT_CYC)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .uart_rx  (uart_rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr)
  );

  // Length decode and in-frame flag used by the FSM below
  always_comb begin
    len_n   = {rx_data, len_lo};
    len_bad = ({1'b0, len_n} > LEN_MAX);
    active  = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
              (state == ST_DATA)   || (state == ST_CSUM);
  end

  // Frame FSM: header/length parse, word assembly, checksum, timeout and framing aborts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      rom_we    <= 1'b0;
      rom_waddr <= '0;
      rom_wdata <= '0;
      cpu_hold  <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      len_lo    <= '0;
      len_words <= '0;
      word_cnt  <= '0;
      byte_cnt  <= '0;
      word_lo   <= '0;
      csum      <= '0;
      tmo_cnt   <= '0;
    end else begin
      rom_we <= 1'b0;

      if (active && !(rx_valid || rx_ferr)) tmo_cnt <= tmo_cnt + 1'b1;
      else                                  tmo_cnt <= '0;

      case (state)
        ST_IDLE: begin
          if (rx_valid && rx_data == HEADER) begin
            state     <= ST_LEN_LO;
            cpu_hold  <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            word_cnt  <= '0;
            byte_cnt  <= '0;
            csum      <= '0;
          end
        end
        ST_LEN_LO: begin
          if (rx_valid) begin
            len_lo <= rx_data;
            state  <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (rx_valid) begin
            len_words <= len_n[ADDR_W:0];
            if (len_bad)                 state <= ST_ERR;
            else if (len_n == '0)        state <= ST_CSUM;
            else                         state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (rx_valid) begin
            csum     <= csum + rx_data;
            byte_cnt <= byte_cnt + 1'b1;
            case (byte_cnt)
              2'd0: word_lo[7:0]   <= rx_data;
              2'd1: word_lo[15:8]  <= rx_data;
              2'd2: word_lo[23:16] <= rx_data;
              default: begin
                rom_we    <= 1'b1;
                rom_waddr <= word_cnt[ADDR_W-1:0];
                rom_wdata <= {rx_data, word_lo};
                word_cnt  <= word_cnt + 1'b1;
                if (word_cnt + 1'b1 == len_words) state <= ST_CSUM;
              end
            endcase
          end
        end
        ST_CSUM: begin
          if (rx_valid) begin
            if (rx_data == csum) begin
              state     <= ST_IDLE;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              state <= ST_ERR;
            end
          end
        end
        ST_ERR: begin
          load_err <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // Framing errors and inter-byte timeouts abort any frame in progress
      if (active && (rx_ferr || tmo_cnt == TMO_LAST)) state <= ST_ERR;
    end
  end

endmodule

// File: tb/tb_uart_rom_loader.sv
// tb/tb_uart_rom_loader.sv - self-checking bench for uart_rom_loader
`timescale 1ns/1ps
module tb_uart_rom_loader;

  localparam int ADDR_W = 4;
  localparam int BITC   = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              uart_rx;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_waddr;
  logic [31:0]       rom_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [ADDR_W-1:0] wr_a[$];
  logic [31:0]       wr_d[$];

  typedef struct {
    int          n;
    logic [7:0]  b [12];
    logic        done;
    logic        err;
    logic        hold;
    int          nwr;
    logic [31:0] d0;
    logic [31:0] d1;
  } vec_t;

  vec_t tbl [3];

  uart_rom_loader #(
    .CLK_FREQ(1_000_000), .BAUD(100_000), .ADDR_W(ADDR_W), .TIMEOUT_CYC(500)
  ) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx),
    .rom_we(rom_we), .rom_waddr(rom_waddr), .rom_wdata(rom_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
  );

  always #500 clk = ~clk;

  always @(negedge clk) begin
    if (rom_we === 1'b1) begin
      wr_a.push_back(rom_waddr);
      wr_d.push_back(rom_wdata);
    end
  end

  initial begin
    #100_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_head(input logic [7:0] b);
    uart_rx = 1'b0;
    idle(BITC);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      idle(BITC);
    end
  endtask

  task automatic send_stop(input logic s);
    uart_rx = s;
    idle(BITC);
    uart_rx = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_head(b);
    send_stop(1'b1);
  endtask

  task automatic check_writes(input string tag, input int nwr, input logic [31:0] d0, input logic [31:0] d1);
    chk({tag, " nwr"}, wr_a.size(), nwr);
    if (wr_a.size() >= 1 && nwr >= 1) begin
      chk({tag, " a0"}, 32'(wr_a[0]), 0);
      chk({tag, " d0"}, wr_d[0], d0);
    end
    if (wr_a.size() >= 2 && nwr >= 2) begin
      chk({tag, " a1"}, 32'(wr_a[1]), 1);
      chk({tag, " d1"}, wr_d[1], d1);
    end
  endtask

  task automatic check_flags(input string tag, input logic done, input logic err, input logic hold);
    chk({tag, " load_done"}, 32'(load_done), 32'(done));
    chk({tag, " load_err"},  32'(load_err),  32'(err));
    chk({tag, " cpu_hold"},  32'(cpu_hold),  32'(hold));
  endtask

  initial begin
    tbl[0].n = 12;
    tbl[0].b = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h82};
    tbl[0].done = 1'b1; tbl[0].err = 1'b0; tbl[0].hold = 1'b0;
    tbl[0].nwr = 2; tbl[0].d0 = 32'h0000_0013; tbl[0].d1 = 32'h0000_006F;

    tbl[1].n = 12;
    tbl[1].b = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h83};
    tbl[1].done = 1'b0; tbl[1].err = 1'b1; tbl[1].hold = 1'b1;
    tbl[1].nwr = 2; tbl[1].d0 = 32'h0000_0013; tbl[1].d1 = 32'h0000_006F;

    tbl[2].n = 3;
    tbl[2].b = '{8'hA5, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[2].done = 1'b0; tbl[2].err = 1'b1; tbl[2].hold = 1'b1;
    tbl[2].nwr = 0; tbl[2].d0 = 32'h0; tbl[2].d1 = 32'h0;

    rst = 1'b1;
    uart_rx = 1'b1;
    idle(5);
    chk("reset rom_we", 32'(rom_we), 0);
    chk("reset rom_waddr", 32'(rom_waddr), 0);
    chk("reset rom_wdata", rom_wdata, 0);
    check_flags("reset", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    idle(20);

    // Table-driven frames: good load, bad checksum, oversize length
    for (int v = 0; v < 3; v++) begin
      wr_a.delete(); wr_d.delete();
      for (int k = 0; k < tbl[v].n; k++) send_byte(tbl[v].b[k]);
      idle(40);
      check_flags($sformatf("vec%0d", v), tbl[v].done, tbl[v].err, tbl[v].hold);
      check_writes($sformatf("vec%0d", v), tbl[v].nwr, tbl[v].d0, tbl[v].d1);
    end

    // Inter-byte timeout: error must appear 500 cycles after the last byte, not earlier
    wr_a.delete(); wr_d.delete();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22);
    chk("timeout header cleared err", 32'(load_err), 0);
    idle(480);
    chk("timeout not early", 32'(load_err), 0);
    idle(40);
    check_flags("timeout", 1'b0, 1'b1, 1'b1);
    idle(80);
    check_writes("timeout", 0, 32'h0, 32'h0);

    // Glitch, stray byte and framing error while idle leave everything unchanged
    uart_rx = 1'b0;
    idle(5);
    uart_rx = 1'b1;
    idle(30);
    send_byte(8'h3C);
    send_head(8'h55);
    send_stop(1'b0);
    idle(30);
    check_flags("noise", 1'b0, 1'b1, 1'b1);
    check_writes("noise", 0, 32'h0, 32'h0);

    // Zero-length frame
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    idle(30);
    check_flags("zero len", 1'b1, 1'b0, 1'b0);
    check_writes("zero len", 0, 32'h0, 32'h0);

    // Reset in the middle of DATA aborts immediately
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00);
    chk("pre-reset hold", 32'(cpu_hold), 1);
    #200;
    rst = 1'b1;
    #10;
    chk("async rst rom_we", 32'(rom_we), 0);
    chk("async rst rom_waddr", 32'(rom_waddr), 0);
    chk("async rst rom_wdata", rom_wdata, 0);
    check_flags("async rst", 1'b0, 1'b0, 1'b0);
    idle(3);
    rst = 1'b0;
    idle(20);

    // Good frame after reset, with cpu_hold edge timing
    wr_a.delete(); wr_d.delete();
    chk("hold before header", 32'(cpu_hold), 0);
    send_head(8'hA5);
    chk("hold during header", 32'(cpu_hold), 0);
    send_stop(1'b1);
    chk("hold after header", 32'(cpu_hold), 1);
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h6F); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_head(8'h82);
    chk("hold before csum stop", 32'(cpu_hold), 1);
    send_stop(1'b1);
    chk("hold after csum", 32'(cpu_hold), 0);
    idle(30);
    check_flags("reload", 1'b1, 1'b0, 1'b0);
    check_writes("reload", 2, 32'h0000_0013, 32'h0000_006F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
